// File: rtl/verificador_linhas.sv
// ----------------------------------------------------------------------------
// verificador_linhas
//
// Scans one 3x3 tic-tac-toe board stored in the board-state RAM and reports
// whether it is won, drawn or still open. The block reads the nine cells
// sequentially (base..base+8, row-major, address wrapping modulo 2^ADDR_W),
// caches them, then evaluates the eight win lines one per cycle. The first
// winning line stops the scan.
//
// Handshake: a scan is accepted on any rising clock edge where iniciar=1 and
// the block is idle (ocupado=0). While ocupado=1, iniciar is ignored and not
// queued. Completion is a single-cycle pronto pulse; vencedor/empate/linha
// are valid from that cycle and hold until the next accepted iniciar.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   iniciar     in   start request (only sampled while idle)
//   base        in   address of cell 0 of the board, latched on acceptance
//   rd_en       out  board RAM read strobe
//   endereco    out  board RAM read address (holds when rd_en=0)
//   rd_data     in   RAM read data, valid one cycle after rd_en
//   ocupado     out  high whenever a scan is in progress (incl. final cycle)
//   pronto      out  one-cycle completion pulse
//   vencedor    out  00 none, 01 player 1, 10 player 2
//   empate      out  board full with no winner
//   linha       out  index of the winning line (0 when no winner)
//   estado_dbg  out  current FSM state, for observation only
// ----------------------------------------------------------------------------
module verificador_linhas #(
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] endereco,
    input  logic [1:0]        rd_data,
    output logic              ocupado,
    output logic              pronto,
    output logic [1:0]        vencedor,
    output logic              empate,
    output logic [2:0]        linha,
    output logic [2:0]        estado_dbg
);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        LE     = 3'd1,
        ESPERA = 3'd2,
        AVALIA = 3'd3,
        FIM    = 3'd4
    } estado_t;

    estado_t           estado_q;
    logic [3:0]        idx_q;
    logic [2:0]        j_q;
    logic [1:0]        cell_q [9];
    logic              rd_en_q;
    logic [ADDR_W-1:0] endereco_q;
    logic              pronto_q;
    logic [1:0]        vencedor_q;
    logic              empate_q;
    logic [2:0]        linha_q;

    // Cell indices of the line currently under evaluation.
    logic [3:0] ia_d, ib_d, ic_d;
    logic [1:0] ca_d, cb_d, cc_d;
    logic       ganha_d;
    logic       cheio_d;

    always_comb begin
        ia_d = 4'd0;
        ib_d = 4'd1;
        ic_d = 4'd2;
        case (j_q)
            3'd0: begin ia_d = 4'd0; ib_d = 4'd1; ic_d = 4'd2; end
            3'd1: begin ia_d = 4'd3; ib_d = 4'd4; ic_d = 4'd5; end
            3'd2: begin ia_d = 4'd6; ib_d = 4'd7; ic_d = 4'd8; end
            3'd3: begin ia_d = 4'd0; ib_d = 4'd3; ic_d = 4'd6; end
            3'd4: begin ia_d = 4'd1; ib_d = 4'd4; ic_d = 4'd7; end
            3'd5: begin ia_d = 4'd2; ib_d = 4'd5; ic_d = 4'd8; end
            3'd6: begin ia_d = 4'd0; ib_d = 4'd4; ic_d = 4'd8; end
            default: begin ia_d = 4'd2; ib_d = 4'd4; ic_d = 4'd6; end
        endcase
        ca_d = cell_q[ia_d];
        cb_d = cell_q[ib_d];
        cc_d = cell_q[ic_d];
        // A player code has exactly one bit set; 00 and 11 can never win.
        ganha_d = (ca_d == cb_d) && (cb_d == cc_d) && (ca_d[0] ^ ca_d[1]);
    end

    // Board is full only if every cell holds a player code (11 counts as empty).
    always_comb begin
        cheio_d = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cheio_d = cheio_d & (cell_q[k][0] ^ cell_q[k][1]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            idx_q      <= 4'd0;
            j_q        <= 3'd0;
            rd_en_q    <= 1'b0;
            endereco_q <= '0;
            pronto_q   <= 1'b0;
            vencedor_q <= 2'b00;
            empate_q   <= 1'b0;
            linha_q    <= 3'd0;
            for (int k = 0; k < 9; k++) begin
                cell_q[k] <= 2'b00;
            end
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        // First read is issued in the very next cycle.
                        endereco_q <= base;
                        rd_en_q    <= 1'b1;
                        idx_q      <= 4'd0;
                        vencedor_q <= 2'b00;
                        empate_q   <= 1'b0;
                        linha_q    <= 3'd0;
                        estado_q   <= LE;
                    end
                end
                LE: begin
                    // Data for the read issued last cycle arrives now.
                    if (idx_q != 4'd0) begin
                        cell_q[idx_q - 4'd1] <= rd_data;
                    end
                    if (idx_q == 4'd8) begin
                        rd_en_q  <= 1'b0;
                        estado_q <= ESPERA;
                    end else begin
                        idx_q      <= idx_q + 4'd1;
                        endereco_q <= endereco_q + 1'b1;
                    end
                end
                ESPERA: begin
                    cell_q[8] <= rd_data;
                    j_q       <= 3'd0;
                    estado_q  <= AVALIA;
                end
                AVALIA: begin
                    if (ganha_d) begin
                        vencedor_q <= ca_d;
                        linha_q    <= j_q;
                        pronto_q   <= 1'b1;
                        estado_q   <= FIM;
                    end else if (j_q == 3'd7) begin
                        empate_q <= cheio_d;
                        pronto_q <= 1'b1;
                        estado_q <= FIM;
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                end
                FIM: begin
                    estado_q <= OCIOSO;
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign rd_en      = rd_en_q;
    assign endereco   = endereco_q;
    assign ocupado    = (estado_q != OCIOSO);
    assign pronto     = pronto_q;
    assign vencedor   = vencedor_q;
    assign empate     = empate_q;
    assign linha      = linha_q;
    assign estado_dbg = estado_q;

endmodule

// File: tb/tb_verificador_linhas.sv
// ----------------------------------------------------------------------------
// Bench for verificador_linhas: a board RAM model answers reads one cycle
// after rd_en; driver tasks load boards and issue iniciar; expected reads and
// results are pushed into queues and checked by a negedge monitor.
// ----------------------------------------------------------------------------
module tb_verificador_linhas;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [1:0] v;
        logic       e;
        logic [2:0] l;
        int         lat;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                cyc;
    } rd_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              iniciar = 1'b0;
    logic [ADDR_W-1:0] base    = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] endereco;
    logic [1:0]        rd_data = 2'b00;
    logic              ocupado;
    logic              pronto;
    logic [1:0]        vencedor;
    logic              empate;
    logic [2:0]        linha;
    logic [2:0]        estado_dbg;

    verificador_linhas #(.ADDR_W(ADDR_W)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .iniciar    (iniciar),
        .base       (base),
        .rd_en      (rd_en),
        .endereco   (endereco),
        .rd_data    (rd_data),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .vencedor   (vencedor),
        .empate     (empate),
        .linha      (linha),
        .estado_dbg (estado_dbg)
    );

    // ---------------- board RAM model ----------------
    logic [1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[endereco];
    end

    // ---------------- scoreboard state ----------------
    exp_t exp_q [$];
    rd_t  addr_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [1:0] board [9];
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                         '{0,3,6}, '{1,4,7}, '{2,5,8},
                         '{0,4,8}, '{2,4,6}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: first line (in scan order) whose three cells hold the same
    // player code wins; otherwise a draw needs all nine cells to be players.
    function automatic exp_t model();
        exp_t r;
        int   players;
        r.v = 2'b00; r.e = 1'b0; r.l = 3'd0; r.lat = 19; r.cyc = 0;
        for (int j = 7; j >= 0; j--) begin
            logic [1:0] a;
            a = board[lines[j][0]];
            if ((a == 2'd1 || a == 2'd2) && board[lines[j][1]] == a && board[lines[j][2]] == a) begin
                r.v = a; r.l = 3'(j); r.lat = 12 + j;
            end
        end
        if (r.v == 2'b00) begin
            players = 0;
            for (int i = 0; i < 9; i++) begin
                if (board[i] == 2'd1 || board[i] == 2'd2) players++;
            end
            r.e = (players == 9);
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rd_en) begin
            if (addr_q.size() == 0) begin
                check("rd_en_unexpected", 32'(rd_en), 32'd0);
            end else begin : pop_rd
                rd_t a;
                a = addr_q.pop_front();
                check("endereco", 32'(endereco), 32'(a.addr));
                check("read_cycle", cyc, a.cyc);
            end
        end
        if (pronto) begin
            if (exp_q.size() == 0) begin
                check("pronto_unexpected", 32'(pronto), 32'd0);
            end else begin : pop_res
                exp_t e;
                e = exp_q.pop_front();
                check("vencedor", 32'(vencedor), 32'(e.v));
                check("empate", 32'(empate), 32'(e.e));
                check("linha", 32'(linha), 32'(e.l));
                check("pronto_cycle", cyc, e.cyc);
                check("ocupado_at_pronto", 32'(ocupado), 32'd1);
            end
        end else if (ocupado) begin
            // Results are cleared at acceptance and only set on the FIM edge.
            check("results_cleared", {vencedor, empate, linha}, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_board(input logic [ADDR_W-1:0] b);
        for (int i = 0; i < 9; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(int'(b) + i);
            mem[a] = board[i];
        end
    endtask

    task automatic push_expect(input int c0, input logic [ADDR_W-1:0] b, output int lat);
        exp_t r;
        r = model();
        r.cyc = c0 + r.lat;
        lat = r.lat;
        exp_q.push_back(r);
        for (int i = 0; i < 9; i++) begin
            rd_t a;
            a.addr = ADDR_W'(int'(b) + i);
            a.cyc  = c0 + 1 + i;
            addr_q.push_back(a);
        end
    endtask

    // Returns #1 after the edge ending the cycle in which the DUT is idle.
    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while ((ocupado || exp_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(ocupado), 32'd0);
    endtask

    // Starts a scan; returns in cycle 1 of that scan with iniciar low.
    task automatic run_scan(input logic [ADDR_W-1:0] b, output int lat);
        wait_idle();
        load_board(b);
        base = b;
        push_expect(cyc, b, lat);
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        base = ADDR_W'($urandom);
    endtask

    task automatic set_board(input int c0, c1, c2, c3, c4, c5, c6, c7, c8);
        board[0] = 2'(c0); board[1] = 2'(c1); board[2] = 2'(c2);
        board[3] = 2'(c3); board[4] = 2'(c4); board[5] = 2'(c5);
        board[6] = 2'(c6); board[7] = 2'(c7); board[8] = 2'(c8);
    endtask

    task automatic random_board();
        int mode;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < 9; i++) begin
            board[i] = (mode == 1) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
        end
        if (mode == 2) begin : force_line
            int j;
            logic [1:0] p;
            j = $urandom_range(0, 7);
            p = 2'($urandom_range(1, 2));
            for (int k = 0; k < 3; k++) board[lines[j][k]] = p;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_endereco"}, 32'(endereco), 32'd0);
        check({tag, "_ocupado"}, 32'(ocupado), 32'd0);
        check({tag, "_pronto"}, 32'(pronto), 32'd0);
        check({tag, "_results"}, {vencedor, empate, linha}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, lat2, c0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(0, 3));

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Row 0 win at base 0: pronto 12 cycles after acceptance.
        set_board(1,1,1, 0,0,0, 0,0,0);
        run_scan(7'd0, lat);

        // Anti-diagonal win by player 2, found on the last line.
        set_board(1,2,2, 1,2,1, 2,1,1);
        run_scan(7'd40, lat);

        // Full board, no winner.
        set_board(1,2,1, 1,2,2, 2,1,1);
        run_scan(7'd17, lat);

        // Reserved code on a row never wins; board still open.
        set_board(3,3,3, 0,0,0, 0,0,0);
        run_scan(7'd60, lat);

        // Draw pattern except cell 8 reserved: not a draw.
        set_board(1,2,1, 1,2,2, 2,1,3);
        run_scan(7'd90, lat);

        // Wrapping base, iniciar pulses in cycle 5 and in FIM are ignored.
        set_board(2,1,2, 1,1,2, 0,1,0);
        run_scan(7'(DEPTH - 3), lat);
        repeat (4) @(posedge clk);
        #1 iniciar = 1'b1;
        @(posedge clk);
        #1 iniciar = 1'b0;
        repeat (lat - 6) @(posedge clk);
        #1 iniciar = 1'b1;
        @(posedge clk);
        #1 iniciar = 1'b0;

        // Back-to-back: iniciar held high restarts in the cycle after FIM.
        set_board(0,2,0, 0,2,0, 1,2,1);
        wait_idle();
        load_board(7'd100);
        base = 7'd100;
        c0 = cyc;
        push_expect(c0, 7'd100, lat);
        push_expect(c0 + lat + 1, 7'd100, lat2);
        iniciar = 1'b1;
        repeat (lat + 2) @(posedge clk);
        #1 iniciar = 1'b0;

        // Reset in cycle 6 aborts the scan with no pronto.
        set_board(1,1,1, 2,2,0, 0,0,0);
        run_scan(7'd5, lat);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1;
        check_reset_values("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);

        // Fresh scan after the abort.
        set_board(2,1,0, 2,1,0, 2,0,1);
        run_scan(7'd5, lat);

        // Randomised boards and bases.
        for (int t = 0; t < 40; t++) begin
            random_board();
            run_scan(7'($urandom), lat);
        end

        wait_idle();
        repeat (5) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("addr_q_drained", addr_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/verificador_linhas.md
# verificador_linhas

Sequencer that scans one 3x3 tic-tac-toe board held in the shared board-state RAM and reports whether it is won, drawn or still open. The game control unit pulses a start after every write to a micro-board or to the macro-board. The block then issues nine sequential reads, caches the cells and evaluates the eight win lines one per cycle. It sits between the control unit and the board RAM read port, replacing ad-hoc combinational win logic with a fixed-latency, time-shared scan.

## Interface
- ADDR_W, default 7: board RAM address width; addresses wrap modulo 2^ADDR_W.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- iniciar  in  1  start request; sampled only in OCIOSO.
- base  in  ADDR_W  address of cell 0 of the board to scan; cells occupy base..base+8, row-major. Latched when iniciar is accepted.
- rd_en  out  1  board RAM read strobe.
- endereco  out  ADDR_W  board RAM read address.
- rd_data  in  2  RAM read data, valid exactly one cycle after rd_en. Cell codes: 00 empty, 01 player 1, 10 player 2, 11 reserved (treated as empty).
- ocupado  out  1  high in every state except OCIOSO.
- pronto  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- vencedor  out  2  00 none, 01 player 1, 10 player 2.
- empate  out  1  all nine cells non-empty and no winner.
- linha  out  3  index of the winning line; 0 when vencedor=00.

## Operation
- States: OCIOSO, LE, ESPERA, AVALIA, FIM.
- OCIOSO:
  - If iniciar=1, latch base, clear idx, clear vencedor/empate/linha, then go to LE.
- LE (9 cycles):
  - rd_en=1, endereco=base+idx, with idx running 0..8.
  - The RAM word returned the following cycle is stored into cell[idx-1].
  - After idx=8, go to ESPERA.
- ESPERA (1 cycle):
  - rd_en=0. Capture cell[8], clear line counter j, go to AVALIA.
- AVALIA (1-8 cycles): one line j per cycle, in this order:
  - j=0..2: rows 012, 345, 678.
  - j=3..5: columns 036, 147, 258.
  - j=6: diagonal 048. j=7: diagonal 246.
  - Win: all three cells equal and in {01,10}. On the first winning line, register vencedor=cell code and linha=j, then go to FIM. Later lines are not evaluated.
  - If j=7 with no win, register empate=1 when no cell is 00 or 11, otherwise empate=0; then go to FIM.
- FIM (1 cycle):
  - pronto=1, then go to OCIOSO.
- Result outputs hold until the next accepted iniciar clears them.
- Code 11 never wins and counts as empty for empate.
- Address arithmetic is modulo 2^ADDR_W; base near the top wraps to 0.

## Timing
- Reset values: state OCIOSO, rd_en=0, endereco=0, ocupado=0, pronto=0, vencedor=00, empate=0, linha=0, cell cache 0.
- Cycle 0 is the cycle in which iniciar is sampled high in OCIOSO.
- Cycles 1-9: LE, ocupado=1, rd_en=1, endereco=base..base+8.
- Cycles 2-10: rd_data captured.
- Cycle 10: ESPERA.
- Cycle 11+j: line j evaluated.
- Win on line j: pronto in cycle 12+j, i.e. 12 cycles minimum for j=0.
- No win: pronto in cycle 19 (maximum latency).
- ocupado stays high through FIM and drops in the cycle after pronto.
- iniciar is ignored while ocupado=1, including the FIM cycle; it is not queued.
- iniciar held high continuously restarts the scan in the cycle after FIM.
- base changes after acceptance have no effect on the current scan.
- Reset asserted mid-scan aborts immediately: all outputs return to reset values, no pronto is produced, and the next scan starts only with a fresh iniciar.
- endereco is don't-care when rd_en=0; it holds its last value.

## Test plan
- Row win: cells base+0..2 = 01, rest 00, base=0 -> reads addresses 0-8 in cycles 1-9; pronto in cycle 12; vencedor=01, linha=0, empate=0.
- Diagonal win: cells 2, 4, 6 = 10, others mixed and non-winning -> pronto in cycle 19; vencedor=10, linha=7.
- Draw: full board 01,10,01 / 01,10,10 / 10,01,01 -> pronto in cycle 19; vencedor=00, empate=1, linha=0.
- Reserved and open board: cells 0-2 = 11, rest 00 -> no win, empate=0. Repeat with cell 8 = 11 and the rest a full draw pattern -> empate=0.
- Busy and wrap: base=2^ADDR_W-3 -> addresses 125,126,127,0..5; an iniciar pulse during cycle 5 is ignored (exactly one pronto); back-to-back iniciar gives a second scan starting after FIM with outputs cleared at acceptance.
- Reset mid-scan: assert reset in cycle 6 -> rd_en=0 and all outputs 0 immediately; no pronto afterwards; a subsequent iniciar produces a correct complete scan.
